// File: rtl/lsu_align_seq.sv
// lsu_align_seq -- load/store alignment sequencer
//
// Sits between the CPU datapath and a byte/half/word data memory. Aligned
// accesses pass straight through combinationally with no stall. Misaligned
// halfword and word accesses are broken into sequential byte accesses while
// the CPU is stalled. All data is little-endian.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned accesses are not split;
//                         they raise misaligned_exc for that cycle, stores
//                         are suppressed and ld_data reads as 0.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high, clears all state
//   req_valid       a load or store is present this cycle
//   req_we          1 = store, 0 = load
//   req_funct3      RISC-V funct3 of the access
//   req_addr        byte address from the ALU
//   req_wdata       store data (rs2)
//   stall           hold PC and pipeline state this cycle
//   ld_data         load result to writeback
//   misaligned_exc  misalignment trap flag (0 unless the trap build is used)
//   mem_wr_en       data memory write enable
//   mem_addr        data memory byte address
//   mem_wr_data     data memory write data
//   mem_funct3      data memory access size/sign code
//   mem_rd_data     data memory combinational read data

module lsu_align_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  misaligned_exc,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Only halfwords on odd addresses and words off a 4-byte boundary are
  // misaligned; every other funct3 (including undefined codes) passes through.
  logic misal;

  always_comb begin
    misal = 1'b0;
    if ((req_funct3 == F3_LH || req_funct3 == F3_LHU) && req_addr[0])
      misal = 1'b1;
    else if (req_funct3 == F3_LW && req_addr[1:0] != 2'b00)
      misal = 1'b1;
  end

`ifdef LSU_MISALIGN_TRAP_EN

  // Trap build: purely combinational, a misaligned request is flagged and
  // neither writes memory nor returns load data.
  always_comb begin
    misaligned_exc = req_valid & misal & ~reset;
    stall          = 1'b0;
    mem_addr       = req_addr;
    mem_wr_data    = req_wdata;
    mem_funct3     = req_funct3;
    mem_wr_en      = req_valid & req_we & ~misal & ~reset;
    ld_data        = (req_valid && misal) ? '0 : mem_rd_data;
  end

`else

  typedef enum logic [1:0] {
    IDLE,
    BYTES,
    DONE
  } state_t;

  state_t                state;
  logic [1:0]            idx;
  logic [1:0]            last_idx;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic                  we_q;
  logic [2:0]            funct3_q;

  // Sequencer state: capture the request on entry, walk one byte per cycle,
  // then spend one cycle in DONE presenting the assembled result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      last_idx  <= 2'd0;
      base_addr <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && misal) begin
            base_addr <= req_addr;
            wdata_q   <= req_wdata;
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            last_idx  <= (req_funct3 == F3_LW) ? 2'd3 : 2'd1;
            idx       <= 2'd0;
            asm_q     <= '0;
            state     <= BYTES;
          end
        end
        BYTES: begin
          if (!we_q)
            asm_q[{idx, 3'b000} +: 8] <= mem_rd_data[7:0];
          idx <= idx + 2'd1;
          if (idx == last_idx)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory and CPU-side outputs. IDLE is a transparent passthrough; reset
  // forces stall and write enable low so nothing is written while it is held.
  always_comb begin
    stall          = 1'b0;
    mem_wr_en      = 1'b0;
    mem_addr       = req_addr;
    mem_wr_data    = req_wdata;
    mem_funct3     = req_funct3;
    ld_data        = mem_rd_data;
    misaligned_exc = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && misal)
          stall = 1'b1;
        else
          mem_wr_en = req_valid & req_we;
      end
      BYTES: begin
        stall       = 1'b1;
        mem_addr    = base_addr + ADDR_WIDTH'(idx);
        mem_funct3  = we_q ? F3_LB : F3_LBU;
        mem_wr_en   = we_q;
        mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[{idx, 3'b000} +: 8]};
        ld_data     = asm_q;
      end
      DONE: begin
        if (we_q)
          ld_data = '0;
        else begin
          case (funct3_q)
            F3_LH:   ld_data = {{(DATA_WIDTH-16){asm_q[15]}}, asm_q[15:0]};
            F3_LHU:  ld_data = {{(DATA_WIDTH-16){1'b0}}, asm_q[15:0]};
            default: ld_data = asm_q;
          endcase
        end
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    if (reset) begin
      stall     = 1'b0;
      mem_wr_en = 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_lsu_align_seq.sv
// tb_lsu_align_seq -- scoreboard testbench for lsu_align_seq
//
// A byte-array data memory is attached to the DUT. A reference memory and
// load model compute expected results when a request is issued; a separate
// monitor checks every byte cycle and every completion against the queue.
//
// Ports: none (top-level bench).

module tb_lsu_align_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        stall;
  logic [31:0] ld_data;
  logic        misaligned_exc;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rd_data;

  lsu_align_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .ld_data        (ld_data),
    .misaligned_exc (misaligned_exc),
    .mem_wr_en      (mem_wr_en),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_funct3     (mem_funct3),
    .mem_rd_data    (mem_rd_data)
  );

  always #5 clk = ~clk;

  // 64-byte memory; high addresses alias onto 0x3C..0x3F, which random
  // traffic never touches, so the wrap-around accesses stay distinct.
  logic [7:0] dmem     [64];
  logic [7:0] gold     [64];
  logic [7:0] init_mem [64];
  bit         do_preload = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit hung     = 1'b0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          misal;
    int          exp_stall;
    bit          chk_ld;
    logic [31:0] exp_ld;
    bit          exp_exc;
  } sb_item_t;

  sb_item_t sb[$];

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Memory read path: combinational, sized and extended by funct3.
  always_comb begin
    logic [5:0]  a;
    logic [31:0] w;
    a = mem_addr[5:0];
    w = {dmem[a + 6'd3], dmem[a + 6'd2], dmem[a + 6'd1], dmem[a]};
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{w[7]}}, w[7:0]};
      3'b100:  mem_rd_data = {24'h0, w[7:0]};
      3'b001:  mem_rd_data = {{16{w[15]}}, w[15:0]};
      3'b101:  mem_rd_data = {16'h0, w[15:0]};
      default: mem_rd_data = w;
    endcase
  end

  // Memory write path; also loads the initial image during the first reset.
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_mem[i];
    end else if (mem_wr_en) begin
      for (int i = 0; i < 4; i++)
        if (i < nbytes(mem_funct3))
          dmem[6'(32'(mem_addr[5:0]) + i)] <= mem_wr_data[8*i +: 8];
    end
  end

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int          sz;
    logic [31:0] v;
    sz = nbytes(f3);
    v  = 32'h0;
    for (int i = 0; i < sz; i++)
      v = v | (32'(gold[6'(addr + 32'(i))]) << (8 * i));
    if (!f3[2]) begin
      if (sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < nbytes(f3); i++)
      gold[6'(addr + 32'(i))] = wdata[8*i +: 8];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issue one request, hold it until the DUT drops stall, and scramble the
  // request inputs while stalled since the captured copy must be used.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    sb_item_t it;
    int       sz;
    int       c;
    if (hung) return;
    sz       = nbytes(f3);
    it.we    = we;
    it.f3    = f3;
    it.addr  = addr;
    it.wdata = wdata;
    it.misal = (sz > 1) && ((addr % sz) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
    it.exp_exc   = it.misal;
    it.exp_stall = 0;
    if (it.misal) begin
      it.chk_ld = 1'b1;
      it.exp_ld = 32'h0;
    end else if (we) begin
      it.chk_ld = 1'b0;
      it.exp_ld = 32'h0;
      model_store(f3, addr, wdata);
    end else begin
      it.chk_ld = 1'b1;
      it.exp_ld = model_load(f3, addr);
    end
`else
    it.exp_exc   = 1'b0;
    it.exp_stall = it.misal ? sz + 1 : 0;
    if (we) begin
      it.chk_ld = it.misal;
      it.exp_ld = 32'h0;
      model_store(f3, addr, wdata);
    end else begin
      it.chk_ld = 1'b1;
      it.exp_ld = model_load(f3, addr);
    end
`endif
    sb.push_back(it);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    c = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      if (c >= 10) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL stall_timeout: stall still 1 after %0d cycles, expected release", c);
        hung = 1'b1;
        break;
      end
      c++;
      @(posedge clk);
      #1;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom_range(0, 7));
      req_we     = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: checks every stalled cycle of the in-flight request and pops
  // the scoreboard when the DUT completes it.
  initial begin
    sb_item_t cur;
    int       mon_cyc;
    int       k;
    mon_cyc = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && req_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_underflow: DUT completed a request with no expected entry");
        end else begin
          cur = sb[0];
          if (stall) begin
            if (mon_cyc == 0) begin
              checkOutput("capture_wr_en", 32'(mem_wr_en), 32'h0);
            end else begin
              k = mon_cyc - 1;
              checkOutput("byte_addr", mem_addr, cur.addr + 32'(k));
              checkOutput("byte_funct3", 32'(mem_funct3), cur.we ? 32'h0 : 32'h4);
              checkOutput("byte_wr_en", 32'(mem_wr_en), 32'(cur.we));
              if (cur.we && k < 4)
                checkOutput("byte_wdata", 32'(mem_wr_data[7:0]), 32'(cur.wdata[8*k +: 8]));
            end
            mon_cyc++;
          end else begin
            void'(sb.pop_front());
            checkOutput("stall_cycles", 32'(mon_cyc), 32'(cur.exp_stall));
            checkOutput("misaligned_exc", 32'(misaligned_exc), 32'(cur.exp_exc));
            checkOutput("done_wr_en", 32'(mem_wr_en), 32'(cur.we && !cur.misal));
            if (cur.chk_ld)
              checkOutput("ld_data", ld_data, cur.exp_ld);
            if (!cur.misal) begin
              checkOutput("pass_addr", mem_addr, cur.addr);
              checkOutput("pass_funct3", 32'(mem_funct3), 32'(cur.f3));
            end
            mon_cyc = 0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] dmem_word(input int w);
    return {dmem[4*w + 3], dmem[4*w + 2], dmem[4*w + 1], dmem[4*w]};
  endfunction

  initial begin
    logic [31:0] preload;
    preload = 32'h0;
    for (int i = 0; i < 64; i++) begin
      init_mem[i] = 8'($urandom);
      gold[i]     = init_mem[i];
    end
    for (int i = 0; i < 12; i++) begin
      case (i / 4)
        0:       preload = 32'h4433_2211;
        1:       preload = 32'h8877_6655;
        default: preload = 32'h0000_00AA;
      endcase
      init_mem[i] = preload[8*(i%4) +: 8];
      gold[i]     = init_mem[i];
    end

    // Reset state, with a misaligned store held on the inputs meanwhile.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h1;
    #1;
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_wr_en", 32'(mem_wr_en), 32'h0);
    checkOutput("reset_exc", 32'(misaligned_exc), 32'h0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_preload = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Aligned lw, misaligned lw, halfwords across the word1/word2 boundary.
    applyStimulus(1'b0, 3'b010, 32'h4, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h1, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h7, 32'h0);
    applyStimulus(1'b0, 3'b101, 32'h7, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h3, 32'h0);

    // Misaligned word store across word0/word1.
    applyStimulus(1'b1, 3'b010, 32'h2, 32'hDEAD_BEEF);
`ifndef LSU_MISALIGN_TRAP_EN
    checkOutput("s4_word0", dmem_word(0), 32'hBEEF_2211);
    checkOutput("s4_word1", dmem_word(1), 32'h8877_DEAD);

    // Restore, then reset in the middle of the same store (during byte 2).
    applyStimulus(1'b1, 3'b010, 32'h0, 32'h4433_2211);
    applyStimulus(1'b1, 3'b010, 32'h4, 32'h8877_6655);
    mon_en     = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h2;
    req_wdata  = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("s5_stall_before", 32'(stall), 32'h1);
    checkOutput("s5_addr_byte2", mem_addr, 32'h4);
    reset = 1'b1;
    #1;
    checkOutput("s5_stall_reset", 32'(stall), 32'h0);
    checkOutput("s5_wr_en_reset", 32'(mem_wr_en), 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    gold[2] = 8'hEF;
    gold[3] = 8'hBE;
    checkOutput("s5_word0", dmem_word(0), 32'hBEEF_2211);
    checkOutput("s5_word1", dmem_word(1), 32'h8877_6655);
    mon_en = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h4, 32'h0);
`else
    checkOutput("s6_word0", dmem_word(0), 32'h4433_2211);
    applyStimulus(1'b1, 3'b010, 32'h1, 32'h1234_5678);
    checkOutput("s6_word0_kept", dmem_word(0), 32'h4433_2211);
    applyStimulus(1'b0, 3'b010, 32'h4, 32'h0);
`endif

    // Address wrap-around at the top of the address space.
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0);
    applyStimulus(1'b1, 3'b001, 32'hFFFF_FFFF, $urandom);
    applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0);
    applyStimulus(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h0, 32'h0);

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      logic       we;
      logic [2:0] f3;
      int         pick;
      we   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 4);
      if (we)
        f3 = (pick < 2) ? 3'b000 : (pick < 3) ? 3'b001 : 3'b010;
      else begin
        case (pick)
          0:       f3 = 3'b000;
          1:       f3 = 3'b100;
          2:       f3 = 3'b001;
          3:       f3 = 3'b101;
          default: f3 = 3'b010;
        endcase
      end
      applyStimulus(we, f3, 32'($urandom_range(0, 44)), $urandom);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    for (int w = 0; w < 16; w++)
      checkOutput($sformatf("mem_word%0d", w), dmem_word(w),
                  {gold[4*w + 3], gold[4*w + 2], gold[4*w + 1], gold[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
